mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 151 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: latches operands on Start_E, stays busy for a
// fixed number of cycles, then commits HI/LO. Define MDU_MADD_EN to enable MADD/MADDU.
module mdu_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start_E,
    input  logic [2:0]  MDOp_E,
    input  logic [31:0] SrcA_E,
    input  logic [31:0] SrcB_E,
    input  logic        WeHI_E,
    input  logic        WeLO_E,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [2:0]  op_reg;
    logic [31:0] a_reg, b_reg, hi_reg, lo_reg;

    logic op_legal, op_is_div, accept, commit;

    always_comb begin
        op_legal  = 1'b0;
        op_is_div = (MDOp_E == 3'd2) || (MDOp_E == 3'd3);
        case (MDOp_E)
            3'd0, 3'd1, 3'd2, 3'd3: op_legal = 1'b1;
`ifdef MDU_MADD_EN
            3'd4, 3'd5:             op_legal = 1'b1;
`else
            3'd4, 3'd5:             op_legal = 1'b0;
`endif
            default:                op_legal = 1'b0;
        endcase
    end

    assign accept = (state_reg == IDLE) && Start_E && op_legal;
    assign commit = (state_reg == RUN) && (cnt_reg == 4'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                    cnt_next   = op_is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            RUN: begin
                cnt_next = cnt_reg - 4'd1;
                if (commit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Busy = (state_reg == RUN);
    end

    // Even ops (MULT, DIV, MADD) are signed, odd ops unsigned.
    logic        is_signed;
    logic [63:0] ext_a, ext_b, product;
    assign is_signed = ~op_reg[0];
    assign ext_a   = is_signed ? {{32{a_reg[31]}}, a_reg} : {32'd0, a_reg};
    assign ext_b   = is_signed ? {{32{b_reg[31]}}, b_reg} : {32'd0, b_reg};
    assign product = ext_a * ext_b;

    // Divide on magnitudes, then restore signs; 0x80000000 / -1 wraps to itself naturally.
    logic        neg_a, neg_b, div_zero;
    logic [31:0] mag_a, mag_b, divisor, q_mag, r_mag, quot, rem;
    assign neg_a    = is_signed && a_reg[31];
    assign neg_b    = is_signed && b_reg[31];
    assign mag_a    = neg_a ? (~a_reg + 32'd1) : a_reg;
    assign mag_b    = neg_b ? (~b_reg + 32'd1) : b_reg;
    assign div_zero = (b_reg == 32'd0);
    assign divisor  = div_zero ? 32'd1 : mag_b;
    assign q_mag    = mag_a / divisor;
    assign r_mag    = mag_a % divisor;
    assign quot     = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    assign rem      = neg_a ? (~r_mag + 32'd1) : r_mag;

`ifdef MDU_MADD_EN
    logic [63:0] acc_sum;
    assign acc_sum = {hi_reg, lo_reg} + product;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg <= 3'd0;
            a_reg  <= 32'd0;
            b_reg  <= 32'd0;
            hi_reg <= 32'd0;
            lo_reg <= 32'd0;
        end else begin
            if (accept) begin
                op_reg <= MDOp_E;
                a_reg  <= SrcA_E;
                b_reg  <= SrcB_E;
            end
            if (commit) begin
                case (op_reg)
                    3'd0, 3'd1: {hi_reg, lo_reg} <= product;
                    3'd2, 3'd3: begin
                        if (div_zero) begin
                            hi_reg <= a_reg;
                            lo_reg <= 32'hFFFF_FFFF;
                        end else begin
                            hi_reg <= rem;
                            lo_reg <= quot;
                        end
                    end
`ifdef MDU_MADD_EN
                    3'd4, 3'd5: {hi_reg, lo_reg} <= acc_sum;
`endif
                    default: ;
                endcase
            end else if (state_reg == IDLE && !accept) begin
                if (WeHI_E) hi_reg <= SrcA_E;
                if (WeLO_E) lo_reg <= SrcA_E;
            end
        end
    end

    assign HI = hi_reg;
    assign LO = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized traffic against
// an arithmetic reference model. Honors MDU_MADD_EN the same way as the design.
module tb_mdu_ctrl;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] srca, srcb;
    logic        wehi, welo;
    logic [31:0] hi, lo;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    mdu_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Start_E(start),
        .MDOp_E (mdop),
        .SrcA_E (srca),
        .SrcB_E (srcb),
        .WeHI_E (wehi),
        .WeLO_E (welo),
        .HI     (hi),
        .LO     (lo),
        .Busy   (busy)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_hi, m_lo, m_a, m_b;
    logic [2:0]  m_op;
    int          m_left;

`ifdef MDU_MADD_EN
    localparam bit MADD_ON = 1'b1;
`else
    localparam bit MADD_ON = 1'b0;
`endif

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, b, h, l);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return ua * ub;
            3'd2, 3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 3'd3) return {a % b, a / b};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin p = 64'(sa * sb); return {h, l} + p; end
            3'd5: return {h, l} + ua * ub;
            default: return {h, l};
        endcase
    endfunction

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_op = 0; m_left = 0;
    endtask

    task automatic model_step();
        logic [63:0] res;
        bit          legal;
        if (!rst_n) return;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                res  = ref_result(m_op, m_a, m_b, m_hi, m_lo);
                m_hi = res[63:32];
                m_lo = res[31:0];
            end
        end else begin
            legal = (mdop <= 3'd3) || (MADD_ON && (mdop == 3'd4 || mdop == 3'd5));
            if (start && legal) begin
                m_op = mdop; m_a = srca; m_b = srcb;
                m_left = (mdop == 3'd2 || mdop == 3'd3) ? DIV_CYC : MULT_CYC;
            end else begin
                if (wehi) m_hi = srca;
                if (welo) m_lo = srca;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", {31'd0, busy}, {31'd0, m_left > 0});
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            cyc();
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, b,
                          input int exp_cyc, input logic [31:0] exp_hi, exp_lo, input string nm);
        int n;
        start = 1'b1; mdop = op; srca = a; srcb = b;
        cyc();
        start = 1'b0;
        wait_idle(n);
        chk({nm, "_busy_cycles"}, 32'(n), 32'(exp_cyc));
        chk({nm, "_hi"}, hi, exp_hi);
        chk({nm, "_lo"}, lo, exp_lo);
    endtask

    task automatic mt(input bit h, input logic [31:0] v);
        wehi = h; welo = ~h; srca = v;
        cyc();
        wehi = 1'b0; welo = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] hold;
        rst_n = 1'b0; start = 0; mdop = 0; srca = 0; srcb = 0; wehi = 0; welo = 0;
        model_reset();
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        cyc();

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg");
        run_op(3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, "divu_100_7");
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, "div_ovf");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'd1, "multu_max");

        // Divide by zero with a second Start_E on busy cycle 3
        start = 1'b1; mdop = 3'd2; srca = 32'd5; srcb = 32'd0;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        start = 1'b1; mdop = 3'd0; srca = 32'd9; srcb = 32'd9;
        cyc();
        start = 1'b0;
        wait_idle(n);
        chk("div0_busy_cycles", 32'(n + 3), 32'd10);
        chk("div0_hi", hi, 32'd5);
        chk("div0_lo", lo, 32'hFFFF_FFFF);

        // MTHI while busy is dropped, in idle it lands next cycle
        start = 1'b1; mdop = 3'd3; srca = 32'd100; srcb = 32'd7;
        cyc();
        start = 1'b0;
        hold = hi;
        mt(1'b1, 32'h1234);
        chk("mthi_busy_hi", hi, hold);
        wait_idle(n);
        chk("mthi_after_op_hi", hi, 32'd2);
        mt(1'b1, 32'h1234);
        chk("mthi_idle_hi", hi, 32'h1234);

        // Reserved op is ignored
        start = 1'b1; mdop = 3'd7; srca = 32'd3; srcb = 32'd3;
        cyc();
        start = 1'b0;
        chk("reserved_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid MULTU
        start = 1'b1; mdop = 3'd1; srca = 32'd7; srcb = 32'd9;
        cyc();
        start = 1'b0;
        cyc();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("areset_busy", {31'd0, busy}, 32'd0);
        chk("areset_hi", hi, 32'd0);
        chk("areset_lo", lo, 32'd0);
        #1 rst_n = 1'b1;
        start = 1'b1; mdop = 3'd3; srca = 32'd1; srcb = 32'd1;
        cyc();
        start = 1'b0;
        chk("post_reset_accept", {31'd0, busy}, 32'd1);
        wait_idle(n);
        chk("post_reset_lo_not63", lo, 32'd1);

        // MADDU accumulate (or ignored when the feature is compiled out)
        mt(1'b1, 32'd0);
        mt(1'b0, 32'hFFFF_FFFF);
        if (MADD_ON)
            run_op(3'd5, 32'd1, 32'd1, 5, 32'd1, 32'd0, "maddu");
        else
            run_op(3'd5, 32'd1, 32'd1, 0, 32'd0, 32'hFFFF_FFFF, "maddu_off");

        // Randomized traffic; the per-cycle compare does the checking
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            mdop  = 3'($urandom_range(0, 7));
            srca  = $urandom;
            case ($urandom_range(0, 4))
                0:       srcb = 32'd0;
                1:       srcb = 32'($urandom_range(1, 20));
                2:       begin srca = 32'h8000_0000; srcb = 32'hFFFF_FFFF; end
                default: srcb = $urandom;
            endcase
            wehi = ($urandom_range(0, 7) == 0);
            welo = ($urandom_range(0, 7) == 0);
            cyc();
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1 rst_n = 1'b1;
            end
        end
        start = 0; wehi = 0; welo = 0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
